// File: rtl/layer_seq_counter.sv
// layer_seq_counter
//
// Two-level MAC sequencing counter for one fully-connected layer. The input
// index steps across n_in MAC operations per neuron, and the neuron index
// steps across n_out neurons. All state changes on the falling edge of clk.
//
// Optional feature macro: FN_LAYER_SEQ_OVF_EN adds the sticky 'ovf' output.
// It flags a MAC ack that arrives while the counter is not running.
//
// Parameters:
//   IN_W        width of in_idx / n_in
//   OUT_W       width of out_idx / n_out
// Ports:
//   clk         clock (falling-edge active)
//   rst         synchronous, active-high reset
//   start       begin a layer pass; latches n_in / n_out (IDLE or DONE only)
//   n_in        MAC steps per neuron (0 treated as 1)
//   n_out       neurons per layer (0 treated as 1)
//   ack         one MAC step completed
//   in_idx      current input index
//   out_idx     current neuron index
//   busy        high while running
//   ack_neuron  one-cycle pulse when a neuron's last step is acked
//   ack_mac     layer-done level, held until start or rst
//   ovf         (FN_LAYER_SEQ_OVF_EN only) sticky spurious-ack flag

module layer_seq_counter #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  n_in,
  input  logic [OUT_W-1:0] n_out,
  input  logic             ack,
  output logic [IN_W-1:0]  in_idx,
  output logic [OUT_W-1:0] out_idx,
  output logic             busy,
  output logic             ack_neuron,
  output logic             ack_mac
`ifdef FN_LAYER_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [IN_W-1:0]  len_in_q, len_in_d;
  logic [OUT_W-1:0] len_out_q, len_out_d;

  logic [IN_W-1:0]  in_idx_d;
  logic [OUT_W-1:0] out_idx_d;
  logic             busy_d;
  logic             ack_neuron_d;
  logic             ack_mac_d;

`ifdef FN_LAYER_SEQ_OVF_EN
  logic ovf_d;
`endif

  // Requested lengths with 0 mapped to 1, so every pass is at least one step.
  logic [IN_W-1:0]  n_in_eff;
  logic [OUT_W-1:0] n_out_eff;

  assign n_in_eff  = (n_in == '0) ? IN_W'(1) : n_in;
  assign n_out_eff = (n_out == '0) ? OUT_W'(1) : n_out;

  // Indices never exceed len-1, so equality is enough to detect the last step.
  logic last_in;
  logic last_out;

  assign last_in  = (in_idx == (len_in_q - IN_W'(1)));
  assign last_out = (out_idx == (len_out_q - OUT_W'(1)));

  always_comb begin
    state_d      = state_q;
    len_in_d     = len_in_q;
    len_out_d    = len_out_q;
    in_idx_d     = in_idx;
    out_idx_d    = out_idx;
    busy_d       = busy;
    ack_neuron_d = 1'b0;
    ack_mac_d    = ack_mac;
`ifdef FN_LAYER_SEQ_OVF_EN
    ovf_d        = ovf;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_in_d  = n_in_eff;
          len_out_d = n_out_eff;
          in_idx_d  = '0;
          out_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = StRun;
`ifdef FN_LAYER_SEQ_OVF_EN
          ovf_d     = 1'b0;
`endif
        end else if (ack) begin
`ifdef FN_LAYER_SEQ_OVF_EN
          ovf_d = 1'b1;
`endif
        end
      end

      StRun: begin
        // start is ignored here; only ack advances the counters.
        if (ack) begin
          if (!last_in) begin
            in_idx_d = in_idx + IN_W'(1);
          end else begin
            in_idx_d     = '0;
            ack_neuron_d = 1'b1;
            if (!last_out) begin
              out_idx_d = out_idx + OUT_W'(1);
            end else begin
              out_idx_d = '0;
              ack_mac_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = StDone;
            end
          end
        end
      end

      StDone: begin
        // start wins over a coincident ack; that ack is dropped uncounted.
        if (start) begin
          len_in_d  = n_in_eff;
          len_out_d = n_out_eff;
          in_idx_d  = '0;
          out_idx_d = '0;
          ack_mac_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = StRun;
`ifdef FN_LAYER_SEQ_OVF_EN
          ovf_d     = 1'b0;
`endif
        end else if (ack) begin
`ifdef FN_LAYER_SEQ_OVF_EN
          ovf_d = 1'b1;
`endif
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_in_q   <= '0;
      len_out_q  <= '0;
      in_idx     <= '0;
      out_idx    <= '0;
      busy       <= 1'b0;
      ack_neuron <= 1'b0;
      ack_mac    <= 1'b0;
`ifdef FN_LAYER_SEQ_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_in_q   <= len_in_d;
      len_out_q  <= len_out_d;
      in_idx     <= in_idx_d;
      out_idx    <= out_idx_d;
      busy       <= busy_d;
      ack_neuron <= ack_neuron_d;
      ack_mac    <= ack_mac_d;
`ifdef FN_LAYER_SEQ_OVF_EN
      ovf        <= ovf_d;
`endif
    end
  end

endmodule
